// File: rtl/serial_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_alu_pkg
//  Description : Shared definitions for the serial carry-lookahead ALU:
//                controller state encodings, datapath slice width and the
//                helper that sizes the slice counter.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_alu_pkg;

    // Bits handled by the lookahead datapath in one clock cycle.
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that must reach n-1. Never returns less than 1 so
    // the counter stays a legal vector even for a single slice.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_cla_alu_ctrl_cla4_slice.sv
`default_nettype none
// ============================================================================
//  Module      : cla4_slice
//  Description : 4-bit carry-lookahead adder slice. Produces the slice sum
//                and the group generate/propagate terms so the caller can
//                form the slice carry-out as G | (P & cin).
//  Ports       : a4, b4  - slice operand bits
//                cin     - carry into bit 0 of the slice
//                sum4    - slice sum
//                G, P    - group generate / group propagate
//  Revision    : 1.0  initial release
// ============================================================================
module cla4_slice (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       cin,
    output logic [3:0] sum4,
    output logic       G,
    output logic       P
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    // Propagate is the inclusive OR; a^b is recovered as p & ~g.
    assign w_g = a4 & b4;
    assign w_p = a4 | b4;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign sum4 = (w_p & ~w_g) ^ w_c;

    assign G = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign P = &w_p;

endmodule
`default_nettype wire

// File: rtl/serial_cla_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_cla_alu_ctrl
//  Description : Serial add/subtract unit. An accepted request is processed
//                4 bits per cycle through a carry-lookahead slice, LSB slice
//                first; after WIDTH/4 cycles the result and flags are held
//                with out_valid until the consumer takes them.
//  Parameters  : WIDTH - operand/result width, multiple of 4, >= 8
//  Macros      : SERIAL_ALU_SUB_EN - when defined op_sub selects subtraction;
//                otherwise op_sub is ignored and the unit only adds.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid/in_ready, op_sub, a, b   - request
//                out_valid/out_ready, result,
//                carry_out, overflow, zero         - response
//                busy                              - slices in progress
//  Revision    : 1.0  initial release
// ============================================================================
module serial_cla_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    localparam int              c_NUM_SLICES = WIDTH / SLICE_W;
    localparam int              c_CNT_W      = cnt_width(c_NUM_SLICES);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(c_NUM_SLICES - 1);

    state_t             r_state;
    state_t             w_state_next;

    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_c;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_zero;

    logic [WIDTH-1:0]   w_b_eff;
    logic               w_c0;
    logic               w_accept;
    logic               w_last;
    logic [3:0]         w_sum4;
    logic               w_g;
    logic               w_p;
    logic               w_carry_next;
    logic [WIDTH-1:0]   w_acc_next;

    // ------------------------------------------------------------------
    // Operand conditioning: subtraction is a + ~b + 1.
    // ------------------------------------------------------------------
`ifdef SERIAL_ALU_SUB_EN
    assign w_b_eff = op_sub ? ~b : b;
    assign w_c0    = op_sub;
`else
    logic w_unused_op_sub;
    assign w_unused_op_sub = op_sub;
    assign w_b_eff         = b;
    assign w_c0            = 1'b0;
`endif

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_state == ST_BUSY) && (r_cnt == c_LAST);

    // ------------------------------------------------------------------
    // Per-cycle lookahead datapath on the low slice of the operand regs.
    // ------------------------------------------------------------------
    cla4_slice u_slice (
        .a4   (r_a[SLICE_W-1:0]),
        .b4   (r_b[SLICE_W-1:0]),
        .cin  (r_c),
        .sum4 (w_sum4),
        .G    (w_g),
        .P    (w_p)
    );

    assign w_carry_next = w_g | (w_p & r_c);
    // Slice sums enter from the top so after N shifts slice 0 sits at the LSB.
    assign w_acc_next   = {w_sum4, r_acc[WIDTH-1:SLICE_W]};

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_c         <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_c     <= w_c0;
            r_cnt   <= '0;
            // Sign bits are shifted out during the operation, so keep them.
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= w_b_eff[WIDTH-1];
        end else if (r_state == ST_BUSY) begin
            r_a   <= r_a >> SLICE_W;
            r_b   <= r_b >> SLICE_W;
            r_c   <= w_carry_next;
            r_acc <= w_acc_next;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                // Visible result only updates here, so it holds through
                // DONE and the following IDLE period.
                r_result    <= w_acc_next;
                r_carry_out <= w_carry_next;
                r_overflow  <= (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
                r_zero      <= (w_acc_next == '0);
            end
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_cla_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_cla_alu_ctrl
//  Description : Self-checking bench for serial_cla_alu_ctrl. The driver
//                issues directed and random requests and pushes the expected
//                response; a monitor pops and compares whenever out_valid
//                rises, and checks latency and hold stability.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_cla_alu_ctrl;

    localparam int W = 32;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic         busy;

    serial_cla_alu_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         z;
        int           due;
        int           hold;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic msub, input int due, input int hold);
        exp_t   e;
        bit     do_sub;
        longint ua, ub, full, sa, sb, ss;
        do_sub = msub;
`ifndef SERIAL_ALU_SUB_EN
        do_sub = 1'b0;
`endif
        ua = longint'({32'd0, ma});
        ub = longint'({32'd0, mb});
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (do_sub) begin
            full = ua - ub;
            e.co = (ua >= ub);
            ss   = sa - sb;
        end else begin
            full = ua + ub;
            e.co = full[W];
            ss   = sa + sb;
        end
        e.res  = full[W-1:0];
        e.ov   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        e.z    = (e.res == '0);
        e.due  = due;
        e.hold = hold;
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return W'($urandom);
        endcase
    endfunction

    // Wait for in_ready while toggling in_valid and operands as noise;
    // nothing presented while in_ready is low may be accepted.
    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!in_ready) begin
            in_valid = 1'($urandom);
            a        = W'($urandom);
            b        = W'($urandom);
            op_sub   = 1'($urandom);
            @(negedge clk);
            guard++;
            if (guard > 500) begin
                $display("FAIL wait_ready: in_ready never returned");
                $fatal(1);
            end
        end
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isub, input int hold);
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        op_sub   = isub;
        q.push_back(model(ia, ib, isub, cyc + 1 + N, hold));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin : monitor
        bit   active;
        exp_t cur;
        int   hold;
        active = 1'b0;
        hold   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                out_ready = 1'b0;
                active    = 1'b0;
            end else if (out_valid) begin
                if (!active) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out_valid", 64'd1, 64'd0);
                    end else begin
                        cur = q.pop_front();
                        chk("latency", 64'(cyc), 64'(cur.due));
                        chk("result", 64'(result), 64'(cur.res));
                        chk("flags{co,ov,z}", {61'd0, carry_out, overflow, zero},
                            {61'd0, cur.co, cur.ov, cur.z});
                        hold = cur.hold;
                    end
                    active = 1'b1;
                end else begin
                    chk("hold_stable{res,co,ov,z,in_ready}",
                        {29'd0, result, carry_out, overflow, zero, in_ready},
                        {29'd0, cur.res, cur.co, cur.ov, cur.z, 1'b0});
                end
                if (hold > 0) begin
                    out_ready = 1'b0;
                    hold--;
                end else begin
                    out_ready = 1'b1;
                    active    = 1'b0;
                end
            end else begin
                out_ready = 1'($urandom);
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    initial begin : driver
        int guard;
        repeat (3) @(negedge clk);
        chk("reset_outputs{ov,busy,res,co,ov,z}",
            {29'd0, out_valid, busy, result, carry_out, overflow, zero}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        issue(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        issue(32'h0000_0003, 32'h0000_0005, 1'b1, 2);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 0);

        for (int i = 0; i < 120; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(pick(), pick(), 1'($urandom), int'($urandom_range(0, 6)));
        end

        // Reset in the middle of an operation: nothing must come out.
        guard = 0;
        while ((q.size() != 0 || !in_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        a        = 32'h1234_5678;
        b        = 32'h1111_1111;
        op_sub   = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_before_reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midop_reset{ov,busy,res,co,ov,z}",
            {29'd0, out_valid, busy, result, carry_out, overflow, zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_release", 64'(in_ready), 64'd1);
        chk("no_out_valid_after_release", 64'(out_valid), 64'd0);

        issue(32'h0000_0005, 32'h0000_0003, 1'b0, 1);
        for (int i = 0; i < 20; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        guard = 0;
        while ((q.size() != 0 || out_valid) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
